sram_nr1w: RTL and testbench
============================

# sram_nr1w

Parametrised synchronous SRAM model with N read ports and one write port. It replaces the fixed 2-read/1-write, 128-bit, 16-bit-address memory in the histogram-equalisation test harness and in the scratch-buffer instances. Over the old memory it adds:

- configurable width, depth and read-port count;
- per-lane write masking;
- selectable read latency (1 or 2 cycles);
- a defined read/write collision policy;
- read-valid strobes;
- a sticky out-of-range error.

## Interface
Parameters:
- DATA_WIDTH, 128, word width in bits; must be a multiple of LANE_WIDTH
- LANE_WIDTH, 8, write-mask granularity in bits
- ADDR_WIDTH, 16, address width
- DEPTH, 65536, number of words; must be ≤ 2^ADDR_WIDTH
- NUM_READ, 2, number of read ports; range 1..4
- READ_LATENCY, 1, cycles from address sample to data; 1 or 2
- WRITE_MODE, 0, collision policy; 0 = READ_FIRST, 1 = WRITE_FIRST

Ports:
- clock  in  1  single clock; all activity on the rising edge
- reset  in  1  synchronous, active-low reset
- we  in  1  write enable
- write_mask  in  DATA_WIDTH/LANE_WIDTH  per-lane write enable; bit i covers bits [i*LANE_WIDTH +: LANE_WIDTH]
- write_address  in  ADDR_WIDTH  write word address
- write_bus  in  DATA_WIDTH  write data
- read_en  in  NUM_READ  per-port read request
- read_address  in  NUM_READ*ADDR_WIDTH  port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH]
- read_bus  out  NUM_READ*DATA_WIDTH  port p drives slice [p*DATA_WIDTH +: DATA_WIDTH]
- read_valid  out  NUM_READ  high for exactly one cycle when that port's data is on read_bus
- oob_error  out  1  sticky; set by any enabled access with address ≥ DEPTH

## Operation
- **Write:**
  - A write is committed at the rising edge when reset=1, we=1 and write_address < DEPTH.
  - Only lanes whose write_mask bit is 1 are updated; all other lanes keep their contents.
  - we=1 with write_mask all zero is legal and changes nothing.
- **Read:** port p samples read_address at the rising edge when reset=1 and read_en[p]=1.
- **Port independence:** ports are fully independent. Any number of ports may read the same address in the same cycle.
- **Collision** (read on port p and write to the same address at the same edge):
  - READ_FIRST: the port returns the pre-write word.
  - WRITE_FIRST: the port returns the merged word, i.e. masked lanes from write_bus and unmasked lanes old.
- **Out of range:**
  - A read with address ≥ DEPTH returns all-zero data with read_valid still asserted, and sets oob_error.
  - A write with address ≥ DEPTH is dropped and sets oob_error.
- **Idle port:** when read_en[p]=0, read_bus slice p holds its last value and read_valid[p]=0.
- **Reset** (reset=0 at an edge):
  - read_bus is cleared to 0, read_valid to 0 and oob_error to 0.
  - All in-flight read-pipeline stages are flushed; no read_valid is generated for requests sampled before reset.
  - Writes and reads presented during reset are ignored.
  - Memory contents are not cleared.
- **Initial contents:** the array is exposed as a hierarchical `Register` array so benches can load and dump it with $readmemh/$writememh.

## Timing
- **READ_LATENCY=1:** address sampled at edge N; read_bus and read_valid are valid after edge N and stay valid until edge N+1.
- **READ_LATENCY=2:** data is registered once more and is valid after edge N+1. A port can issue back-to-back requests every cycle; throughput is 1 word per port per cycle.
- **Collision sampling:** collision resolution uses the write present at edge N (the address-sample edge) only. A write at edge N+1 does not affect the data of a latency-2 read sampled at edge N.
- **Write visibility:** a write at edge N is visible to any read sampled at edge N+1 or later, in either mode.
- **oob_error:** asserts the cycle after the offending edge and stays high until reset.
- **Reset mid-operation:** reset=0 at edge M suppresses every read_valid that would have appeared after edge M.

## Structure
- Package sram_pkg holds:
  - WRITE_MODE constants READ_FIRST=0 and WRITE_FIRST=1;
  - a function computing mask width (DATA_WIDTH/LANE_WIDTH);
  - an elaboration-time parameter check: DATA_WIDTH % LANE_WIDTH == 0, DEPTH ≤ 2^ADDR_WIDTH, READ_LATENCY ∈ {1,2}, NUM_READ in 1..4.
- One natural sub-module, sram_read_port. It holds the address-sample stage, the collision merge, the out-of-range zeroing and the optional second register stage with its valid pipeline. It is instantiated NUM_READ times in a generate loop. The top level owns the array and the write logic.

## Test plan
- **Masked write:**
  - Reset, then write 0x00..00 to address 5 with mask 0xFFFF; next cycle write 0xFF..FF with mask 0x0001; read address 5 on port 0.
  - Required: read_bus = 0x00..00FF with read_valid one cycle after the sample edge (latency 1).
- **Collision, READ_FIRST:**
  - Address 10 holds 0xAAAA…; in the same cycle write 0x5555… (mask all ones) and read address 10 on ports 0 and 1.
  - Required: both ports return 0xAAAA…; a read the next cycle returns 0x5555….
- **Collision, WRITE_FIRST:** same stimulus with mask 0x00FF. Required: returned word is the upper 8 lanes 0xAA and the lower 8 lanes 0x55.
- **Pipelining, READ_LATENCY=2:**
  - Issue reads of addresses 0,1,2,3 on consecutive cycles, with addresses preloaded to 0x10..0x13.
  - Required: read_valid high for 4 consecutive cycles starting 2 cycles after the first sample, with data 0x10,0x11,0x12,0x13 in order.
- **Out of range:**
  - With DEPTH=1024, read address 2000. Required: read_bus=0, read_valid=1 and oob_error=1 thereafter.
  - Write to address 1500. Required: array unchanged.
  - Apply reset. Required: oob_error=0.
- **Reset mid-read:**
  - With READ_LATENCY=2, issue a read at edge N and assert reset=0 at edge N+1.
  - Required: no read_valid pulse, read_bus=0, and memory contents preserved (verified after reset release).

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants, mask-width helper and parameter check for sram_nr1w
package sram_pkg;

  // Collision policy selectors for WRITE_MODE.
  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  function automatic int maskWidth(input int dataWidth, input int laneWidth);
    return dataWidth / laneWidth;
  endfunction

  // Returns 1 when the parameter set describes a buildable memory.
  function automatic bit paramsOk(input int dataWidth, input int laneWidth,
                                  input int addrWidth, input int depth,
                                  input int numRead, input int readLatency,
                                  input int writeMode);
    bit ok;
    ok = 1'b1;
    if (laneWidth < 1 || dataWidth < laneWidth || (dataWidth % laneWidth) != 0) ok = 1'b0;
    if (addrWidth < 1 || addrWidth > 62) ok = 1'b0;
    else if (depth < 1 || longint'(depth) > (longint'(1) << addrWidth)) ok = 1'b0;
    if (numRead < 1 || numRead > 4) ok = 1'b0;
    if (readLatency != 1 && readLatency != 2) ok = 1'b0;
    if (writeMode != READ_FIRST && writeMode != WRITE_FIRST) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sram_read_port.sv
// rtl/sram_read_port.sv - one read port: sample, collision merge, range zeroing, optional second stage
//   clock, reset     : rising-edge clock, synchronous active-low reset
//   readEn           : request; readAddress sampled at the edge where this is high
//   memWord          : array contents at readAddress before the current edge's write
//   writeCommit      : a write to writeAddress lands at this edge; mergedWord is its result
//   readData         : held word, cleared by reset
//   readValid        : one-cycle strobe per request
//   oobHit           : this cycle's request is out of range
module sram_read_port
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 65536,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = READ_FIRST
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  readEn,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] memWord,
  input  logic                  writeCommit,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] mergedWord,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  readValid,
  output logic                  oobHit
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  inRange;
  logic                  collide;
  logic [DATA_WIDTH-1:0] sampleWord;
  logic [DATA_WIDTH-1:0] stageData;
  logic                  stageValid;

  assign inRange = {1'b0, readAddress} < DEPTH_LIMIT;
  assign collide = writeCommit && (readAddress == writeAddress);
  assign oobHit  = readEn && !inRange;

  // memWord is already the pre-write word, so READ_FIRST needs no special case.
  always_comb begin
    sampleWord = memWord;
    if (!inRange) begin
      sampleWord = '0;
    end else if (WRITE_MODE == WRITE_FIRST && collide) begin
      sampleWord = mergedWord;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stageData  <= '0;
      stageValid <= 1'b0;
    end else begin
      stageValid <= readEn;
      if (readEn) begin
        stageData <= sampleWord;
      end
    end
  end

  if (READ_LATENCY == 2) begin : gTwoStage
    logic [DATA_WIDTH-1:0] outData;
    logic                  outValid;

    // Data was resolved at the sample edge; this stage only delays it.
    always_ff @(posedge clock) begin
      if (!reset) begin
        outData  <= '0;
        outValid <= 1'b0;
      end else begin
        outValid <= stageValid;
        if (stageValid) begin
          outData <= stageData;
        end
      end
    end

    assign readData  = outData;
    assign readValid = outValid;
  end else begin : gOneStage
    assign readData  = stageData;
    assign readValid = stageValid;
  end

endmodule

// File: rtl/sram_nr1w.sv
// rtl/sram_nr1w.sv - synchronous SRAM model, NUM_READ read ports and one lane-masked write port
//   clock, reset   : rising-edge clock, synchronous active-low reset
//   we, write_*    : write request; write_mask bit i enables lane i
//   read_en        : per-port request, read_address slice p is port p
//   read_bus       : slice p is port p data, read_valid[p] its strobe
//   oob_error      : sticky flag for any enabled access at or beyond DEPTH
module sram_nr1w
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 128,
  parameter int LANE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 65536,
  parameter int NUM_READ     = 2,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = READ_FIRST
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        we,
  input  logic [maskWidth(DATA_WIDTH, LANE_WIDTH)-1:0] write_mask,
  input  logic [ADDR_WIDTH-1:0]                       write_address,
  input  logic [DATA_WIDTH-1:0]                       write_bus,
  input  logic [NUM_READ-1:0]                         read_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]              read_address,
  output logic [NUM_READ*DATA_WIDTH-1:0]              read_bus,
  output logic [NUM_READ-1:0]                         read_valid,
  output logic                                        oob_error
);

  localparam int MASK_WIDTH = maskWidth(DATA_WIDTH, LANE_WIDTH);
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  if (!paramsOk(DATA_WIDTH, LANE_WIDTH, ADDR_WIDTH, DEPTH, NUM_READ,
                READ_LATENCY, WRITE_MODE)) begin : gBadParams
    $error("sram_nr1w: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] Register [DEPTH];

  logic                  writeInRange;
  logic                  writeCommit;
  logic [IDX_W-1:0]      writeIndex;
  logic [DATA_WIDTH-1:0] oldWord;
  logic [DATA_WIDTH-1:0] mergedWord;
  logic [NUM_READ-1:0]   portOob;

  assign writeInRange = {1'b0, write_address} < DEPTH_LIMIT;
  assign writeCommit  = we && writeInRange;
  assign writeIndex   = write_address[IDX_W-1:0];
  assign oldWord      = Register[writeIndex];

  // The full merged word is written back; WRITE_FIRST ports reuse it.
  always_comb begin
    mergedWord = oldWord;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (write_mask[i]) begin
        mergedWord[i*LANE_WIDTH +: LANE_WIDTH] = write_bus[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset && writeCommit) begin
      Register[writeIndex] <= mergedWord;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : gReadPort
    logic [ADDR_WIDTH-1:0] portAddress;
    logic [DATA_WIDTH-1:0] portWord;

    assign portAddress = read_address[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign portWord    = Register[portAddress[IDX_W-1:0]];

    sram_read_port #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DEPTH       (DEPTH),
      .READ_LATENCY(READ_LATENCY),
      .WRITE_MODE  (WRITE_MODE)
    ) uReadPort (
      .clock       (clock),
      .reset       (reset),
      .readEn      (read_en[p]),
      .readAddress (portAddress),
      .memWord     (portWord),
      .writeCommit (writeCommit),
      .writeAddress(write_address),
      .mergedWord  (mergedWord),
      .readData    (read_bus[p*DATA_WIDTH +: DATA_WIDTH]),
      .readValid   (read_valid[p]),
      .oobHit      (portOob[p])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      oob_error <= 1'b0;
    end else if ((we && !writeInRange) || (|portOob)) begin
      oob_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_nr1w.sv
// tb/tb_sram_nr1w.sv - scoreboard bench for sram_nr1w (READ_FIRST/WRITE_FIRST latency 1, READ_FIRST latency 2)
module tb_sram_nr1w;

  typedef struct {
    int           cyc;
    logic [127:0] data;
  } rd_t;

  typedef struct {
    int           d;
    int           kind;
    int           cyc;
    logic [255:0] exp;
  } chk_t;

  localparam logic [127:0] ALL1   = {128{1'b1}};
  localparam logic [127:0] PAT_A  = {16{8'hAA}};
  localparam logic [127:0] PAT_5  = {16{8'h55}};
  localparam logic [127:0] MERGED = {{8{8'hAA}}, {8{8'h55}}};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic         resetn [3];
  logic         we     [3];
  logic [15:0]  wMask  [3];
  logic [15:0]  wAddr  [3];
  logic [127:0] wBus   [3];
  logic [1:0]   rEn    [3];
  logic [31:0]  rAddr  [3];
  logic [255:0] rBus   [3];
  logic [1:0]   rValid [3];
  logic         oob    [3];

  int lat [3] = '{1, 1, 2};

  rd_t  rdQ [6][$];
  chk_t chkQ [$];

  int vectors     = 0;
  int miscompares = 0;
  bit done        = 1'b0;

  sram_nr1w #(.DATA_WIDTH(128), .LANE_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(1024),
              .NUM_READ(2), .READ_LATENCY(1), .WRITE_MODE(0)) dut0 (
    .clock(clock), .reset(resetn[0]), .we(we[0]), .write_mask(wMask[0]),
    .write_address(wAddr[0]), .write_bus(wBus[0]), .read_en(rEn[0]),
    .read_address(rAddr[0]), .read_bus(rBus[0]), .read_valid(rValid[0]),
    .oob_error(oob[0]));

  sram_nr1w #(.DATA_WIDTH(128), .LANE_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(1024),
              .NUM_READ(2), .READ_LATENCY(1), .WRITE_MODE(1)) dut1 (
    .clock(clock), .reset(resetn[1]), .we(we[1]), .write_mask(wMask[1]),
    .write_address(wAddr[1]), .write_bus(wBus[1]), .read_en(rEn[1]),
    .read_address(rAddr[1]), .read_bus(rBus[1]), .read_valid(rValid[1]),
    .oob_error(oob[1]));

  sram_nr1w #(.DATA_WIDTH(128), .LANE_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(1024),
              .NUM_READ(2), .READ_LATENCY(2), .WRITE_MODE(0)) dut2 (
    .clock(clock), .reset(resetn[2]), .we(we[2]), .write_mask(wMask[2]),
    .write_address(wAddr[2]), .write_bus(wBus[2]), .read_en(rEn[2]),
    .read_address(rAddr[2]), .read_bus(rBus[2]), .read_valid(rValid[2]),
    .oob_error(oob[2]));

  task automatic step();
    @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      we[d]  = 1'b0;
      rEn[d] = 2'b00;
    end
  endtask

  task automatic wr(input int d, input logic [15:0] a, input logic [127:0] v,
                    input logic [15:0] m);
    we[d]    = 1'b1;
    wAddr[d] = a;
    wBus[d]  = v;
    wMask[d] = m;
  endtask

  task automatic rd(input int d, input int p, input logic [15:0] a,
                    input logic [127:0] e);
    rd_t t;
    rEn[d][p]              = 1'b1;
    rAddr[d][p*16 +: 16]   = a;
    t.cyc                  = cyc + lat[d];
    t.data                 = e;
    rdQ[d*2+p].push_back(t);
  endtask

  // kind 0: oob_error, 1: read_valid, 2: read_bus; compared at the coming falling edge
  task automatic chk(input int d, input int kind, input logic [255:0] e);
    chk_t c;
    c.d    = d;
    c.kind = kind;
    c.cyc  = cyc;
    c.exp  = e;
    chkQ.push_back(c);
  endtask

  always @(negedge clock) begin
    rd_t          t;
    chk_t         c;
    logic [255:0] act;
    int           idx;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        idx = d*2 + p;
        while (rdQ[idx].size() > 0 && rdQ[idx][0].cyc < cyc) begin
          t = rdQ[idx].pop_front();
          vectors++;
          miscompares++;
          $display("FAIL rd_missing dut%0d port%0d: no read_valid at cycle %0d, want data %h",
                   d, p, t.cyc, t.data);
        end
        if (rValid[d][p] === 1'b1) begin
          vectors++;
          if (rdQ[idx].size() == 0) begin
            miscompares++;
            $display("FAIL rd_unexpected dut%0d port%0d: read_valid=1 data %h at cycle %0d, want no strobe",
                     d, p, rBus[d][p*128 +: 128], cyc);
          end else begin
            t = rdQ[idx].pop_front();
            if (t.cyc != cyc || rBus[d][p*128 +: 128] !== t.data) begin
              miscompares++;
              $display("FAIL rd_data dut%0d port%0d: got %h at cycle %0d, want %h at cycle %0d",
                       d, p, rBus[d][p*128 +: 128], cyc, t.data, t.cyc);
            end
          end
        end
      end
    end
    while (chkQ.size() > 0 && chkQ[0].cyc <= cyc) begin
      c = chkQ.pop_front();
      act = '0;
      case (c.kind)
        0:       act[0]   = oob[c.d];
        1:       act[1:0] = rValid[c.d];
        default: act      = rBus[c.d];
      endcase
      vectors++;
      if (act !== c.exp) begin
        miscompares++;
        $display("FAIL state dut%0d kind%0d cycle %0d: got %h, want %h",
                 c.d, c.kind, cyc, act, c.exp);
      end
    end
    if (done) begin
      for (int i = 0; i < 6; i++) begin
        while (rdQ[i].size() > 0) begin
          t = rdQ[i].pop_front();
          vectors++;
          miscompares++;
          $display("FAIL rd_missing slot%0d: no read_valid by end, want data %h at cycle %0d",
                   i, t.data, t.cyc);
        end
      end
      while (chkQ.size() > 0) begin
        c = chkQ.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL state_unchecked dut%0d kind%0d: got none, want %h", c.d, c.kind, c.exp);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      resetn[d] = 1'b0;
      we[d]     = 1'b0;
      wMask[d]  = '0;
      wAddr[d]  = '0;
      wBus[d]   = '0;
      rEn[d]    = '0;
      rAddr[d]  = '0;
    end
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      chk(d, 0, 256'd0);
      chk(d, 1, 256'd0);
      chk(d, 2, 256'd0);
    end
    for (int d = 0; d < 3; d++) resetn[d] = 1'b1;
    step();

    // dut0: masked write, then hold on idle
    wr(0, 16'd5, 128'd0, 16'hFFFF); step();
    wr(0, 16'd5, ALL1, 16'h0001);   step();
    rd(0, 0, 16'd5, 128'hFF);       step();
    step();
    chk(0, 1, 256'd0);
    chk(0, 2, {128'd0, 128'hFF});

    // dut0: READ_FIRST collision on both ports, then write visibility
    wr(0, 16'd10, PAT_A, 16'hFFFF); step();
    wr(0, 16'd10, PAT_5, 16'hFFFF);
    rd(0, 0, 16'd10, PAT_A);
    rd(0, 1, 16'd10, PAT_A);        step();
    rd(0, 0, 16'd10, PAT_5);        step();

    // dut0: all-zero mask changes nothing
    wr(0, 16'd5, ALL1, 16'h0000);   step();
    rd(0, 1, 16'd5, 128'hFF);       step();

    // dut0: out-of-range read and write, sticky flag, cleared by reset
    wr(0, 16'd476, 128'h1234, 16'hFFFF); step();
    chk(0, 0, 256'd0);
    rd(0, 1, 16'd2000, 128'd0);     step();
    chk(0, 0, 256'd1);
    wr(0, 16'd1500, ALL1, 16'hFFFF); step();
    rd(0, 0, 16'd476, 128'h1234);
    rd(0, 1, 16'd5, 128'hFF);       step();
    chk(0, 0, 256'd1);
    resetn[0] = 1'b0;               step();
    chk(0, 0, 256'd0);
    chk(0, 1, 256'd0);
    chk(0, 2, 256'd0);
    resetn[0] = 1'b1;               step();

    // dut1: WRITE_FIRST collision with lower-half mask
    wr(1, 16'd10, PAT_A, 16'hFFFF); step();
    wr(1, 16'd10, PAT_5, 16'h00FF);
    rd(1, 0, 16'd10, MERGED);
    rd(1, 1, 16'd10, MERGED);       step();
    rd(1, 0, 16'd10, MERGED);       step();

    // dut2: latency-2 back-to-back reads
    for (int i = 0; i < 4; i++) begin
      wr(2, 16'(i), 128'(8'h10 + i), 16'hFFFF);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      rd(2, 0, 16'(i), 128'(8'h10 + i));
      rd(2, 1, 16'(3 - i), 128'(8'h13 - i));
      step();
    end
    step(); step();

    // dut2: a write one edge after the sample does not affect that read
    rd(2, 0, 16'd0, 128'h10);       step();
    wr(2, 16'd0, 128'h99, 16'hFFFF); step();
    rd(2, 0, 16'd0, 128'h99);       step();
    step(); step();

    // dut2: reset one edge after a sample; traffic during reset is ignored
    rEn[2][1]       = 1'b1;
    rAddr[2][31:16] = 16'd1;        step();
    resetn[2] = 1'b0;
    rEn[2]    = 2'b11;
    rAddr[2]  = {16'd2, 16'd2};
    wr(2, 16'd1, 128'hDEAD, 16'hFFFF); step();
    chk(2, 1, 256'd0);
    chk(2, 2, 256'd0);
    step();
    chk(2, 1, 256'd0);
    resetn[2] = 1'b1;
    rd(2, 0, 16'd1, 128'h11);
    rd(2, 1, 16'd2, 128'h12);       step();
    repeat (4) step();
    done = 1'b1;
  end

endmodule
